udp_tx_arbiter: RTL and testbench
=================================

# udp_tx_arbiter

- Packet-granular round-robin arbiter that shares the single 32-bit AXI-Stream UDP transmit input of the Ethernet/UDP/ARP core between N_SRC requesters.
- Sits in the `aclk` domain, between the user-side packet producers and `s_axis_*` of the UDP core.
- Holds the grant from first word to `tlast` and enforces a maximum payload length per datagram.

## Interface
- `N_SRC`, default 4: number of requesters, range 2..8.
- `MAX_WORDS`, default 366: maximum 32-bit words per forwarded datagram (1464 bytes).
- `aclk`  in  1: single clock for all logic.
- `areset`  in  1: reset, synchronous and active-high.
- `s_axis_tdata`  in  N_SRC*32: requester data, source i at bits [32*i+31:32*i].
- `s_axis_tvalid`  in  N_SRC: per-source valid.
- `s_axis_tlast`  in  N_SRC: per-source end of packet.
- `s_axis_tready`  out  N_SRC: per-source ready.
- `m_axis_tdata`  out  32: data to UDP core.
- `m_axis_tvalid`  out  1: valid to UDP core.
- `m_axis_tlast`  out  1: end of datagram.
- `m_axis_tready`  in  1: UDP core ready.
- `grant_id`  out  clog2(N_SRC): index of the current or last granted source.
- `busy`  out  1: high in any state other than IDLE.
- `trunc_pulse`  out  1: one-cycle pulse when a datagram is truncated at MAX_WORDS.

## Operation
- FSM states: IDLE, (TAG), PASS, DROP.
- IDLE:
  - Round-robin search over `s_axis_tvalid`, starting at `last_grant+1` mod N_SRC.
  - On a hit: register `grant_id`, set `last_grant`, clear `word_cnt`, go to PASS (or TAG when the tag feature is compiled in).
  - With no valid source, stay in IDLE.
- PASS:
  - `m_axis_tdata/tvalid/tlast` are a combinational mux of the granted source.
  - `s_axis_tready[grant_id] = m_axis_tready`; all other readies are 0.
  - Each accepted beat (valid & ready) increments `word_cnt`.
  - Accepted beat with source `tlast` → IDLE.
  - Accepted beat where `word_cnt == MAX_WORDS-1` and source `tlast` is 0: force `m_axis_tlast = 1`, pulse `trunc_pulse`, go to DROP.
  - Source `tlast` on exactly word MAX_WORDS is a legal datagram: go to IDLE, no truncation.
- DROP:
  - `s_axis_tready[grant_id] = 1` and `m_axis_tvalid = 0`; the rest of the source packet is discarded.
  - Accepted beat with `tlast` → IDLE.
- `word_cnt` width is clog2(MAX_WORDS+1). It never wraps because it is cleared on each grant.
- A source that deasserts `tvalid` mid-packet keeps the grant; the arbiter waits indefinitely, with no timeout.
- Valid requests that appear while another packet is in progress wait for the next IDLE. Fairness: with all sources always requesting, the grant order is 0,1,2,…,N_SRC-1,0.

## Timing
- Reset values: FSM in IDLE, `last_grant = N_SRC-1` (so source 0 wins first), `grant_id = 0`, `word_cnt = 0`, all `s_axis_tready = 0`, `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `busy = 0`, `trunc_pulse = 0`.
- Arbitration costs exactly one IDLE cycle per datagram. The first word of a granted packet can transfer in the cycle after the decision.
- Data path latency in PASS is 0 cycles (combinational). Ready propagates combinationally from the UDP core to the source.
- Back-to-back packets from the same or different sources are separated by one bubble cycle.
- `areset` asserted mid-packet returns the FSM to IDLE on the next edge with all outputs at reset values. The partial datagram is abandoned, and the UDP core must be reset together with this block.
- `trunc_pulse` is registered and is high the cycle after the forced-`tlast` beat.

## Configuration
- `UDP_TX_ARB_TAG_EN` defined:
  - TAG state inserted after grant. It emits one header word {8'hA5, 8'(grant_id), 16'(per-source packet counter)} with `tlast = 0`; all `s_axis_tready` are 0 during TAG.
  - The tag word counts toward MAX_WORDS.
  - The per-source 16-bit counters increment when TAG is accepted, wrap at 16'hFFFF → 0, and reset to 0.
- `UDP_TX_ARB_TAG_EN` undefined: no TAG state and no counters; the payload is forwarded unchanged.

## Structure
- Shared package `udp_tx_arb_pkg`: FSM state enum, `TAG_MAGIC = 8'hA5`, `DATA_W = 32`.
- One sub-module, `rr_pick`: combinational round-robin priority picker (request vector, last grant → grant index, hit flag), reusable elsewhere.

## Test plan
- Source 2 only, 3-word packet 0x11,0x22,0x33 → IDLE one cycle, `grant_id = 2`, three beats, `tlast` on 0x33, `busy` falls after the last beat.
- All four sources continuously offer 2-word packets → grant order 0,1,2,3,0, one bubble between packets.
- Source 1 sends MAX_WORDS+5 words → 366 forwarded with `tlast` on word 366, `trunc_pulse` once, 5 words dropped, and source 1 sees ready on every dropped word.
- `m_axis_tready` toggling 1,0,0,1 while source 3 has `tvalid` gaps → no beat lost or duplicated, `s_axis_tready[3]` mirrors `m_axis_tready`.
- `areset` pulsed on the second word of a 4-word packet → all outputs at reset values on the next cycle, and the next grant goes to source 0 if it is requesting.
- With `UDP_TX_ARB_TAG_EN`: two packets from source 1 → header words 0xA5010000 then 0xA5010001 precede the respective payloads.

Source files
------------

// File: rtl/udp_tx_arb_pkg.sv
// Shared types and constants for the UDP transmit arbiter.
package udp_tx_arb_pkg;

    localparam int         DATA_W    = 32;
    localparam logic [7:0] TAG_MAGIC = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TAG,
        ST_PASS,
        ST_DROP
    } arb_state_t;

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; returns the first requester found
// when scanning upward from last+1 (mod N), plus a hit flag.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             hit
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        hit   = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(last) + i) % N);
            if (!hit && req[idx]) begin
                grant = idx;
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the UDP core's AXI-Stream TX input,
// with per-datagram length limiting. Define UDP_TX_ARB_TAG_EN to prepend a tag word.
module udp_tx_arbiter
    import udp_tx_arb_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int MAX_WORDS = 366
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [N_SRC*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]          s_axis_tvalid,
    input  logic [N_SRC-1:0]          s_axis_tlast,
    output logic [N_SRC-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [$clog2(N_SRC)-1:0]  grant_id,
    output logic                      busy,
    output logic                      trunc_pulse
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    arb_state_t          state;
    logic [IDX_W-1:0]    last_grant;
    logic [CNT_W-1:0]    word_cnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_hit;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_valid;
    logic                sel_last;
    logic                at_limit;

`ifdef UDP_TX_ARB_TAG_EN
    logic [15:0]         pkt_cnt [N_SRC];
`endif

    rr_pick #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (s_axis_tvalid),
        .last  (last_grant),
        .grant (pick_idx),
        .hit   (pick_hit)
    );

    assign sel_data  = s_axis_tdata[grant_id*DATA_W +: DATA_W];
    assign sel_valid = s_axis_tvalid[grant_id];
    assign sel_last  = s_axis_tlast[grant_id];
    // The beat that fills the datagram is the one taken while the count reads MAX_WORDS-1.
    assign at_limit  = (word_cnt == CNT_W'(MAX_WORDS - 1));
    assign busy      = (state != ST_IDLE);

    always_comb begin
        // NOTE: every output is given a default first so no branch can infer a latch.
        m_axis_tdata  = sel_data;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (state)
`ifdef UDP_TX_ARB_TAG_EN
            ST_TAG: begin
                m_axis_tdata  = {TAG_MAGIC, 8'(grant_id), pkt_cnt[grant_id]};
                m_axis_tvalid = 1'b1;
            end
`endif
            ST_PASS: begin
                m_axis_tvalid           = sel_valid;
                m_axis_tlast            = sel_valid & (sel_last | at_limit);
                s_axis_tready[grant_id] = m_axis_tready;
            end
            ST_DROP: begin
                s_axis_tready[grant_id] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (areset) begin
            state       <= ST_IDLE;
            last_grant  <= IDX_W'(N_SRC - 1);
            grant_id    <= '0;
            word_cnt    <= '0;
            trunc_pulse <= 1'b0;
`ifdef UDP_TX_ARB_TAG_EN
            // NOTE: this small array is reset explicitly because its contents appear in the tag word.
            for (int i = 0; i < N_SRC; i++) pkt_cnt[i] <= '0;
`endif
        end else begin
            trunc_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_hit) begin
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        word_cnt   <= '0;
`ifdef UDP_TX_ARB_TAG_EN
                        state      <= ST_TAG;
`else
                        state      <= ST_PASS;
`endif
                    end
                end
`ifdef UDP_TX_ARB_TAG_EN
                ST_TAG: begin
                    if (m_axis_tready) begin
                        word_cnt          <= word_cnt + CNT_W'(1);
                        pkt_cnt[grant_id] <= pkt_cnt[grant_id] + 16'd1;
                        state             <= ST_PASS;
                    end
                end
`endif
                ST_PASS: begin
                    if (sel_valid && m_axis_tready) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                        if (sel_last) begin
                            state <= ST_IDLE;
                        end else if (at_limit) begin
                            trunc_pulse <= 1'b1;
                            state       <= ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (sel_valid && sel_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: per-cycle vector table plus hand-written
// truncation / exact-length sequences (tag sequence when UDP_TX_ARB_TAG_EN is defined).
module tb_udp_tx_arbiter;

    localparam int N_SRC     = 4;
    localparam int MAX_WORDS = 366;

    logic                aclk = 1'b0;
    logic                areset = 1'b1;
    logic [N_SRC*32-1:0] s_axis_tdata = '0;
    logic [N_SRC-1:0]    s_axis_tvalid = '0;
    logic [N_SRC-1:0]    s_axis_tlast = '0;
    logic [N_SRC-1:0]    s_axis_tready;
    logic [31:0]         m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tlast;
    logic                m_axis_tready = 1'b0;
    logic [1:0]          grant_id;
    logic                busy;
    logic                trunc_pulse;

    int n_total = 0;
    int n_pass  = 0;

    udp_tx_arbiter #(
        .N_SRC     (N_SRC),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_id      (grant_id),
        .busy          (busy),
        .trunc_pulse   (trunc_pulse)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic        rdy;
        int          dsrc;
        logic [31:0] dat;
        logic        ev;
        logic        el;
        logic [31:0] ed;
        logic [3:0]  es;
        logic [1:0]  eg;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                                 input logic rdy, input int dsrc, input logic [31:0] dat,
                                 input logic ev, input logic el, input logic [31:0] ed,
                                 input logic [3:0] es, input logic [1:0] eg, input logic eb);
        vec_t v;
        v.rst = rst; v.vld = vld; v.lst = lst; v.rdy = rdy; v.dsrc = dsrc; v.dat = dat;
        v.ev = ev; v.el = el; v.ed = ed; v.es = es; v.eg = eg; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Drive one cycle's inputs at the falling edge; the granted source gets d, others junk.
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic rdy, input int dsrc, input logic [31:0] d);
        @(negedge aclk);
        areset        = r;
        s_axis_tvalid = v;
        s_axis_tlast  = l;
        m_axis_tready = rdy;
        for (int i = 0; i < N_SRC; i++)
            s_axis_tdata[i*32 +: 32] = (i == dsrc) ? d : (32'hDEAD_0000 | 32'(i));
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with every source requesting: nothing may be granted or readied.
        drive(1'b1, 4'b1111, 4'b0000, 1'b1, 0, 32'h0);
        drive(1'b1, 4'b1111, 4'b0000, 1'b1, 0, 32'h0);
        check("rst_srdy",   32'(s_axis_tready), 32'h0);
        check("rst_mvalid", 32'(m_axis_tvalid), 32'h0);
        check("rst_mlast",  32'(m_axis_tlast),  32'h0);
        check("rst_gid",    32'(grant_id),      32'h0);
        check("rst_busy",   32'(busy),          32'h0);
        check("rst_trunc",  32'(trunc_pulse),   32'h0);

`ifdef UDP_TX_ARB_TAG_EN
        for (int p = 0; p < 2; p++) begin
            drive(1'b0, 4'b0010, 4'b0000, 1'b1, 1, 32'h0);
            check($sformatf("tag%0d_idle_mvalid", p), 32'(m_axis_tvalid), 32'h0);
            drive(1'b0, 4'b0010, 4'b0000, 1'b1, 1, 32'h7000_0000 + 32'(p));
            check($sformatf("tag%0d_hdr_mvalid", p), 32'(m_axis_tvalid), 32'h1);
            check($sformatf("tag%0d_hdr_data", p),   m_axis_tdata, 32'hA501_0000 + 32'(p));
            check($sformatf("tag%0d_hdr_mlast", p),  32'(m_axis_tlast), 32'h0);
            check($sformatf("tag%0d_hdr_srdy", p),   32'(s_axis_tready), 32'h0);
            drive(1'b0, 4'b0010, 4'b0010, 1'b1, 1, 32'h7000_0000 + 32'(p));
            check($sformatf("tag%0d_pay_data", p),   m_axis_tdata, 32'h7000_0000 + 32'(p));
            check($sformatf("tag%0d_pay_mlast", p),  32'(m_axis_tlast), 32'h1);
            check($sformatf("tag%0d_pay_srdy", p),   32'(s_axis_tready), 32'h2);
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, 0, 32'h0);
        check("tag_end_busy", 32'(busy), 32'h0);
`else
        // Source 2 alone: one IDLE cycle, three beats, tlast on 0x33; then reset.
        vecs.push_back(mkv(0, 4'b0100, 4'b0000, 1, 2, 32'h00, 0, 0, 32'h00, 4'b0000, 0, 0));
        vecs.push_back(mkv(0, 4'b0100, 4'b0000, 1, 2, 32'h11, 1, 0, 32'h11, 4'b0100, 2, 1));
        vecs.push_back(mkv(0, 4'b0100, 4'b0000, 1, 2, 32'h22, 1, 0, 32'h22, 4'b0100, 2, 1));
        vecs.push_back(mkv(0, 4'b0100, 4'b0100, 1, 2, 32'h33, 1, 1, 32'h33, 4'b0100, 2, 1));
        vecs.push_back(mkv(1, 4'b0000, 4'b0000, 1, 0, 32'h00, 0, 0, 32'h00, 4'b0000, 2, 0));
        // All sources offering 2-word packets: order 0,1,2,3,0 with one bubble each.
        vecs.push_back(mkv(0, 4'b1111, 4'b0000, 1, 0, 32'h00, 0, 0, 32'h00, 4'b0000, 0, 0));
        for (int s = 0; s < N_SRC; s++) begin
            vecs.push_back(mkv(0, 4'b1111, 4'b0000, 1, s, 32'hA000_0000 + 32'(s*16),
                               1, 0, 32'hA000_0000 + 32'(s*16), 4'(1 << s), 2'(s), 1));
            vecs.push_back(mkv(0, 4'b1111, 4'(1 << s), 1, s, 32'hA000_0001 + 32'(s*16),
                               1, 1, 32'hA000_0001 + 32'(s*16), 4'(1 << s), 2'(s), 1));
            vecs.push_back(mkv(0, 4'b1111, 4'b0000, 1, 0, 32'h00, 0, 0, 32'h00, 4'b0000, 2'(s), 0));
        end
        vecs.push_back(mkv(0, 4'b1111, 4'b0000, 1, 0, 32'hA000_0100, 1, 0, 32'hA000_0100, 4'b0001, 0, 1));
        vecs.push_back(mkv(0, 4'b1111, 4'b0001, 1, 0, 32'hA000_0101, 1, 1, 32'hA000_0101, 4'b0001, 0, 1));
        vecs.push_back(mkv(0, 4'b1000, 4'b0000, 1, 0, 32'h00, 0, 0, 32'h00, 4'b0000, 0, 0));
        // Source 3 with valid gaps while m_axis_tready goes 1,0,0,1.
        vecs.push_back(mkv(0, 4'b1000, 4'b0000, 1, 3, 32'hC0, 1, 0, 32'hC0, 4'b1000, 3, 1));
        vecs.push_back(mkv(0, 4'b1000, 4'b0000, 0, 3, 32'hC1, 1, 0, 32'hC1, 4'b0000, 3, 1));
        vecs.push_back(mkv(0, 4'b0000, 4'b0000, 0, 3, 32'hC1, 0, 0, 32'h00, 4'b0000, 3, 1));
        vecs.push_back(mkv(0, 4'b0000, 4'b0000, 1, 3, 32'hC1, 0, 0, 32'h00, 4'b1000, 3, 1));
        vecs.push_back(mkv(0, 4'b1000, 4'b0000, 1, 3, 32'hC1, 1, 0, 32'hC1, 4'b1000, 3, 1));
        vecs.push_back(mkv(0, 4'b1000, 4'b1000, 0, 3, 32'hC2, 1, 1, 32'hC2, 4'b0000, 3, 1));
        vecs.push_back(mkv(0, 4'b1000, 4'b1000, 1, 3, 32'hC2, 1, 1, 32'hC2, 4'b1000, 3, 1));
        vecs.push_back(mkv(0, 4'b0001, 4'b0000, 1, 0, 32'h00, 0, 0, 32'h00, 4'b0000, 3, 0));
        // Reset on the second word of source 0's packet; 0 then wins over 1.
        vecs.push_back(mkv(0, 4'b0001, 4'b0000, 1, 0, 32'hD0, 1, 0, 32'hD0, 4'b0001, 0, 1));
        vecs.push_back(mkv(1, 4'b0001, 4'b0000, 1, 0, 32'hD1, 1, 0, 32'hD1, 4'b0001, 0, 1));
        vecs.push_back(mkv(0, 4'b0011, 4'b0000, 1, 0, 32'h00, 0, 0, 32'h00, 4'b0000, 0, 0));
        vecs.push_back(mkv(0, 4'b0011, 4'b0000, 1, 0, 32'hE0, 1, 0, 32'hE0, 4'b0001, 0, 1));
        vecs.push_back(mkv(0, 4'b0011, 4'b0001, 1, 0, 32'hE1, 1, 1, 32'hE1, 4'b0001, 0, 1));
        vecs.push_back(mkv(0, 4'b0010, 4'b0000, 1, 0, 32'h00, 0, 0, 32'h00, 4'b0000, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].lst, vecs[i].rdy, vecs[i].dsrc, vecs[i].dat);
            check($sformatf("v%0d_mvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                check($sformatf("v%0d_mlast", i), 32'(m_axis_tlast), 32'(vecs[i].el));
                check($sformatf("v%0d_mdata", i), m_axis_tdata, vecs[i].ed);
            end
            check($sformatf("v%0d_srdy", i),  32'(s_axis_tready), 32'(vecs[i].es));
            check($sformatf("v%0d_gid", i),   32'(grant_id),      32'(vecs[i].eg));
            check($sformatf("v%0d_busy", i),  32'(busy),          32'(vecs[i].eb));
            check($sformatf("v%0d_trunc", i), 32'(trunc_pulse),   32'h0);
        end

        // Source 1 (granted by the last vector) sends MAX_WORDS+5 words.
        begin
            int fwd = 0, trunc_cnt = 0, last_pos = -1, data_err = 0, rdy_err = 0;
            for (int w = 0; w < MAX_WORDS + 5; w++) begin
                drive(1'b0, 4'b0010, (w == MAX_WORDS + 4) ? 4'b0010 : 4'b0000, 1'b1, 1,
                      32'h5000_0000 + 32'(w));
                if (m_axis_tvalid && m_axis_tready) begin
                    fwd++;
                    if (m_axis_tdata !== 32'h5000_0000 + 32'(w)) data_err++;
                    if (m_axis_tlast) last_pos = fwd;
                end
                if (s_axis_tready !== 4'b0010) rdy_err++;
                if (trunc_pulse) begin
                    trunc_cnt++;
                    check("trunc_pulse_pos", 32'(w), 32'(MAX_WORDS));
                end
            end
            check("trunc_fwd_count", 32'(fwd),       32'(MAX_WORDS));
            check("trunc_last_pos",  32'(last_pos),  32'(MAX_WORDS));
            check("trunc_pulses",    32'(trunc_cnt), 32'h1);
            check("trunc_data_errs", 32'(data_err),  32'h0);
            check("trunc_rdy_errs",  32'(rdy_err),   32'h0);
        end
        drive(1'b0, 4'b0100, 4'b0000, 1'b1, 2, 32'h0);
        check("post_trunc_busy",  32'(busy),          32'h0);
        check("post_trunc_pulse", 32'(trunc_pulse),   32'h0);
        check("post_trunc_srdy",  32'(s_axis_tready), 32'h0);

        // Source 2 sends exactly MAX_WORDS words: legal, no truncation.
        begin
            int fwd = 0, trunc_cnt = 0, last_pos = -1;
            for (int w = 0; w < MAX_WORDS; w++) begin
                drive(1'b0, 4'b0100, (w == MAX_WORDS - 1) ? 4'b0100 : 4'b0000, 1'b1, 2,
                      32'h6000_0000 + 32'(w));
                if (m_axis_tvalid && m_axis_tready) begin
                    fwd++;
                    if (m_axis_tlast) last_pos = fwd;
                end
                if (trunc_pulse) trunc_cnt++;
            end
            check("exact_fwd_count", 32'(fwd),      32'(MAX_WORDS));
            check("exact_last_pos",  32'(last_pos), 32'(MAX_WORDS));
            drive(1'b0, 4'b0000, 4'b0000, 1'b1, 0, 32'h0);
            if (trunc_pulse) trunc_cnt++;
            check("exact_trunc",     32'(trunc_cnt), 32'h0);
            check("exact_end_busy",  32'(busy),      32'h0);
            check("exact_end_gid",   32'(grant_id),  32'h2);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
